// File: rtl/hazard_pkg.sv
// Shared constants, FSM state type and the opcode-to-source-use decode for hazard_scoreboard.
package hazard_pkg;
  localparam int NREG_DEF   = 32;
  localparam int IDX_W_DEF  = 5;
  localparam int STAT_W_DEF = 16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {HZ_RUN, HZ_STALL, HZ_FLUSH} hz_state_t;

  typedef struct packed {
    logic rs;
    logic rt;
  } src_use_t;

  // Which of the rs/rt fields the ID-stage instruction actually reads.
  function automatic src_use_t src_use(input logic [5:0] op);
    src_use_t u;
    u = '{rs: 1'b0, rt: 1'b0};
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: u = '{rs: 1'b1, rt: 1'b1};
      OP_LW, OP_ADDI:                  u = '{rs: 1'b1, rt: 1'b0};
      default:                         u = '{rs: 1'b0, rt: 1'b0};
    endcase
    return u;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback <-> hazard scoreboard signal bundle; master = pipeline, slave = scoreboard.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int STAT_W = STAT_W_DEF
);
  logic [31:0]       instrD;
  logic              validD;
  logic              regWriteD;
  logic [IDX_W-1:0]  writeRegD;
  logic              branchTakenD;
  logic              wbValidW;
  logic [IDX_W-1:0]  wbRegW;
  logic              stallF;
  logic              stallD;
  logic              flushE;
  logic              flushD;
  logic              rsReady;
  logic              rtReady;
  logic [STAT_W-1:0] stallCount;

  modport master (
    output instrD, validD, regWriteD, writeRegD, branchTakenD, wbValidW, wbRegW,
    input  stallF, stallD, flushE, flushD, rsReady, rtReady, stallCount
  );

  modport slave (
    input  instrD, validD, regWriteD, writeRegD, branchTakenD, wbValidW, wbRegW,
    output stallF, stallD, flushE, flushD, rsReady, rtReady, stallCount
  );
endinterface

// File: rtl/hazard_scoreboard_pending_table.sv
// NREG-bit in-flight write table: one set port, one clear port (set wins), two read ports
// that see a same-cycle writeback clear.
module pending_table
  import hazard_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic             i_clr,
  input  logic [IDX_W-1:0] i_clr_idx,
  input  logic [IDX_W-1:0] i_rd_a,
  input  logic [IDX_W-1:0] i_rd_b,
  output logic             o_pend_a,
  output logic             o_pend_b
);
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;

  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr) w_pend_nxt[i_clr_idx] = 1'b0;
    if (i_set) w_pend_nxt[i_set_idx] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  assign o_pend_a = r_pend[i_rd_a] & ~(i_clr && (i_clr_idx == i_rd_a));
  assign o_pend_b = r_pend[i_rd_b] & ~(i_clr && (i_clr_idx == i_rd_b));
endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard controller for the 5-stage MIPS pipeline: stalls ID on pending sources,
// flushes IF/ID one cycle after a taken branch. Optional stall counter under HAZ_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_scoreboard_if.slave hz
);
  hz_state_t        r_state, w_state_nxt;
  src_use_t         w_use;
  logic             w_flush_st;
  logic             w_pend_rs, w_pend_rt;
  logic             w_hazard;
  logic             w_issue;
  logic [IDX_W-1:0] w_rs, w_rt;
  logic             w_unused;

  assign w_rs       = hz.instrD[25:21];
  assign w_rt       = hz.instrD[20:16];
  assign w_use      = src_use(hz.instrD[31:26]);
  assign w_flush_st = (r_state == HZ_FLUSH);
  assign w_unused   = ^hz.instrD[15:0];

  pending_table #(.NREG(NREG), .IDX_W(IDX_W)) u_pend (
    .clk       (clk),
    .reset     (reset),
    .i_set     (w_issue),
    .i_set_idx (hz.writeRegD),
    .i_clr     (hz.wbValidW),
    .i_clr_idx (hz.wbRegW),
    .i_rd_a    (w_rs),
    .i_rd_b    (w_rt),
    .o_pend_a  (w_pend_rs),
    .o_pend_b  (w_pend_rt)
  );

  // The FLUSH cycle holds a wrong-path fetch: it neither stalls nor issues.
  assign w_hazard = hz.validD & ~w_flush_st &
                    ((w_use.rs & w_pend_rs) | (w_use.rt & w_pend_rt));
  assign w_issue  = hz.validD & hz.regWriteD & ~w_hazard & ~w_flush_st &
                    (hz.writeRegD != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= HZ_RUN;
    else       r_state <= w_state_nxt;
  end

  // A taken branch seen while stalled is deferred until its operands are ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HZ_RUN, HZ_STALL: begin
        if (w_hazard)             w_state_nxt = HZ_STALL;
        else if (hz.branchTakenD) w_state_nxt = HZ_FLUSH;
        else                      w_state_nxt = HZ_RUN;
      end
      HZ_FLUSH: w_state_nxt = HZ_RUN;
      default:  w_state_nxt = HZ_RUN;
    endcase
  end

  assign hz.stallF  = w_hazard;
  assign hz.stallD  = w_hazard;
  assign hz.flushE  = w_hazard;
  assign hz.flushD  = w_flush_st;
  assign hz.rsReady = ~w_pend_rs;
  assign hz.rtReady = ~w_pend_rt;

`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_stall_cnt <= '0;
    else if (w_hazard && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign hz.stallCount = r_stall_cnt;
`else
  assign hz.stallCount = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; outputs sampled 2ns after driving.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_scoreboard_if hz ();

  hazard_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stallF, stallD, flushE, flushD, rsReady, rtReady}
  function automatic logic [5:0] outs();
    return {hz.stallF, hz.stallD, hz.flushE, hz.flushD, hz.rsReady, hz.rtReady};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0020};
  endfunction

  task automatic idle();
    hz.instrD = 32'h0; hz.validD = 1'b0; hz.regWriteD = 1'b0; hz.writeRegD = 5'd0;
    hz.branchTakenD = 1'b0; hz.wbValidW = 1'b0; hz.wbRegW = 5'd0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic rw, input logic [4:0] wr);
    hz.instrD = ins; hz.validD = v; hz.regWriteD = rw; hz.writeRegD = wr;
    #2;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #3;
    checks++;
    if (outs() !== 6'b000011) begin
      failures++; $display("FAIL reset_outs got=%b exp=000011", outs());
    end
    checks++;
    if (hz.stallCount !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", hz.stallCount);
    end
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_raw();
    do_reset();
    drive(mk(OP_RTYPE, 5'd1, 5'd2), 1, 1, 5'd3);
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL raw_issue got=%b exp=000011", outs()); end
    step();
    drive(mk(OP_RTYPE, 5'd3, 5'd3), 1, 1, 5'd4);
    checks++;
    if (outs() !== 6'b111000) begin failures++; $display("FAIL raw_stall1 got=%b exp=111000", outs()); end
    step(); #2;
    checks++;
    if (outs() !== 6'b111000) begin failures++; $display("FAIL raw_stall2 got=%b exp=111000", outs()); end
    hz.wbValidW = 1'b1; hz.wbRegW = 5'd3;
    #1;
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL raw_wb_bypass got=%b exp=000011", outs()); end
    step();
    hz.wbValidW = 1'b0;
    drive(mk(OP_RTYPE, 5'd4, 5'd0), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b111001) begin failures++; $display("FAIL raw_r4_issued got=%b exp=111001", outs()); end
  endtask

  task automatic test_lw_sw();
    do_reset();
    drive(mk(OP_LW, 5'd6, 5'd5), 1, 1, 5'd5);
    step();
    drive(mk(OP_SW, 5'd6, 5'd5), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b111010) begin failures++; $display("FAIL sw_rt got=%b exp=111010", outs()); end
    step();
    drive(mk(6'h02, 5'd5, 5'd5), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b000000) begin failures++; $display("FAIL jump_nouse got=%b exp=000000", outs()); end
    step();
    drive(mk(OP_ADDI, 5'd5, 5'd0), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b111001) begin failures++; $display("FAIL addi_rs got=%b exp=111001", outs()); end
    step();
    drive(mk(OP_BNE, 5'd6, 5'd5), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b111010) begin failures++; $display("FAIL bne_rt got=%b exp=111010", outs()); end
    step();
    drive(mk(OP_LW, 5'd6, 5'd5), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b000010) begin failures++; $display("FAIL lw_rt_unused got=%b exp=000010", outs()); end
    step();
    drive(mk(OP_SW, 5'd6, 5'd5), 0, 0, 5'd0);
    checks++;
    if (outs() !== 6'b000010) begin failures++; $display("FAIL invalid_nostall got=%b exp=000010", outs()); end
  endtask

  task automatic test_r0();
    do_reset();
    drive(mk(OP_RTYPE, 5'd1, 5'd2), 1, 1, 5'd0);
    step();
    drive(mk(OP_RTYPE, 5'd0, 5'd0), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL r0_read got=%b exp=000011", outs()); end
    step(); step();
    drive(mk(OP_SW, 5'd0, 5'd0), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL r0_later got=%b exp=000011", outs()); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(mk(OP_RTYPE, 5'd1, 5'd2), 1, 1, 5'd9);
    step();
    hz.branchTakenD = 1'b1;
    drive(mk(OP_BEQ, 5'd1, 5'd2), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL br_resolve got=%b exp=000011", outs()); end
    step();
    drive(mk(OP_RTYPE, 5'd9, 5'd9), 1, 1, 5'd10);
    checks++;
    if (outs() !== 6'b000100) begin failures++; $display("FAIL br_flush got=%b exp=000100", outs()); end
    step();
    hz.branchTakenD = 1'b0;
    drive(mk(OP_RTYPE, 5'd10, 5'd10), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL br_noissue got=%b exp=000011", outs()); end
    step();
    hz.branchTakenD = 1'b1;
    drive(mk(OP_BEQ, 5'd9, 5'd9), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b111000) begin failures++; $display("FAIL br_hazard got=%b exp=111000", outs()); end
    step(); #2;
    checks++;
    if (outs() !== 6'b111000) begin failures++; $display("FAIL br_deferred got=%b exp=111000", outs()); end
    hz.wbValidW = 1'b1; hz.wbRegW = 5'd9;
    #1;
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL br_release got=%b exp=000011", outs()); end
    step();
    idle();
    #2;
    checks++;
    if (outs() !== 6'b000111) begin failures++; $display("FAIL br_late_flush got=%b exp=000111", outs()); end
    step(); #2;
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL br_back_run got=%b exp=000011", outs()); end
  endtask

  task automatic test_set_wins();
    do_reset();
    hz.wbValidW = 1'b1; hz.wbRegW = 5'd7;
    drive(mk(OP_RTYPE, 5'd1, 5'd2), 1, 1, 5'd7);
    step();
    hz.wbValidW = 1'b0;
    drive(mk(OP_RTYPE, 5'd7, 5'd0), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b111001) begin failures++; $display("FAIL set_wins got=%b exp=111001", outs()); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(mk(OP_RTYPE, 5'd0, 5'd0), 1, 1, 5'd1); step();
    drive(mk(OP_RTYPE, 5'd0, 5'd0), 1, 1, 5'd2); step();
    drive(mk(OP_RTYPE, 5'd0, 5'd0), 1, 1, 5'd3); step();
    drive(mk(OP_RTYPE, 5'd1, 5'd2), 1, 0, 5'd0);
    step(); #2;
    checks++;
    if (outs() !== 6'b111000) begin failures++; $display("FAIL mid_stall got=%b exp=111000", outs()); end
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL async_reset got=%b exp=000011", outs()); end
    checks++;
    if (hz.stallCount !== 16'd0) begin failures++; $display("FAIL async_reset_cnt got=%0d exp=0", hz.stallCount); end
    @(negedge clk);
    reset = 1'b0;
    step();
    drive(mk(OP_RTYPE, 5'd3, 5'd3), 1, 0, 5'd0);
    checks++;
    if (outs() !== 6'b000011) begin failures++; $display("FAIL table_cleared got=%b exp=000011", outs()); end
  endtask

  task automatic test_stall_count();
    logic [15:0] exp_cnt;
`ifdef HAZ_STATS_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    drive(mk(OP_RTYPE, 5'd0, 5'd0), 1, 1, 5'd1);
    step();
    drive(mk(OP_RTYPE, 5'd1, 5'd0), 1, 0, 5'd0);
    for (int i = 0; i < 5; i++) step();
    hz.wbValidW = 1'b1; hz.wbRegW = 5'd1;
    #2;
    checks++;
    if (hz.stallCount !== exp_cnt) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", hz.stallCount, exp_cnt); end
    step();
    hz.wbValidW = 1'b0;
    #2;
    checks++;
    if (hz.stallCount !== exp_cnt) begin failures++; $display("FAIL stall_count_hold got=%0d exp=%0d", hz.stallCount, exp_cnt); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_lw_sw();
    test_r0();
    test_branch();
    test_set_wins();
    test_reset_mid_stall();
    test_stall_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
